// File: rtl/core_sht_data_in.sv
// ---------------------------------------------------------------------------
// core_sht_data_in
//
// Avalon-MM slave input port for the SHT sensor data/status lines. Each input
// bit is brought into the clk domain with a two-flop synchronizer, cleaned by
// a per-bit glitch filter, and watched for edges. Qualifying edges set sticky
// capture bits, which raise a maskable level interrupt.
//
// Parameters
//   WIDTH          number of input bits (1..32)
//   FILTER_CYCLES  cycles a synchronized bit must disagree with its filtered
//                  value before the filtered value follows it (1..65535)
//   EDGE_TYPE      edge that sets a capture bit: 0 rising, 1 falling, 2 any
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   address     register select (0 DATA, 1 reserved, 2 IRQ_MASK,
//               3 EDGE_CAPTURE)
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   readdata    registered read data, one cycle latency
//   in_port     asynchronous external inputs
//   irq         level interrupt, |(edge_capture & irq_mask)
// ---------------------------------------------------------------------------
module core_sht_data_in #(
  parameter int WIDTH         = 8,
  parameter int FILTER_CYCLES = 4,
  parameter int EDGE_TYPE     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  // Synchronizer, filter and register state
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_filt;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_capture;
  logic [31:0]      r_readdata;

  // Next-state and decode wires
  logic [WIDTH-1:0] w_filt_next;
  logic [CW-1:0]    w_cnt_next [WIDTH];
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edges;
  logic [WIDTH-1:0] w_wdata;
  logic             w_wr;
  logic             w_rd;
  logic [31:0]      w_rd_mux;

  // Upper write-data bits are intentionally ignored when WIDTH < 32.
  logic             w_unused_wdata;
  assign w_unused_wdata = ^writedata;

  assign w_wdata = writedata[WIDTH-1:0];
  assign w_wr    = chipselect && !write_n;
  assign w_rd    = chipselect &&  write_n;

  // Glitch filter: a bit's counter runs only while the synchronized value
  // disagrees with the filtered value; any agreement restarts the count, so
  // a pulse shorter than FILTER_CYCLES cycles never gets through.
  // NOTE: every output of an always_comb gets a default before any branch so
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_filt_next = r_filt;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_next[i] = '0;
      if (r_s2[i] != r_filt[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_filt_next[i] = r_s2[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Edges are detected on the filtered value as it is about to change, so the
  // capture bit sets on the same clock edge that the filtered value moves.
  assign w_rise = w_filt_next & ~r_filt;
  assign w_fall = ~w_filt_next & r_filt;

  always_comb begin
    w_edges = '0;
    case (EDGE_TYPE)
      0:       w_edges = w_rise;
      1:       w_edges = w_fall;
      default: w_edges = w_rise | w_fall;
    endcase
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA: w_rd_mux = 32'(r_filt);
      ADDR_MASK: w_rd_mux = 32'(r_irq_mask);
      ADDR_CAP:  w_rd_mux = 32'(r_edge_capture);
      default:   w_rd_mux = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1           <= '0;
      r_s2           <= '0;
      r_filt         <= '0;
      r_irq_mask     <= '0;
      r_edge_capture <= '0;
      r_readdata     <= '0;
    end else begin
      r_s1   <= in_port;
      r_s2   <= r_s1;
      r_filt <= w_filt_next;

      if (w_wr && address == ADDR_MASK) begin
        r_irq_mask <= w_wdata;
      end

      // Clear first, then OR in new edges: a capture in the same cycle as a
      // write-1-to-clear on that bit leaves the bit set.
      if (w_wr && address == ADDR_CAP) begin
        r_edge_capture <= (r_edge_capture & ~w_wdata) | w_edges;
      end else begin
        r_edge_capture <= r_edge_capture | w_edges;
      end

      if (w_rd) begin
        r_readdata <= w_rd_mux;
      end
    end
  end

  // NOTE: the counter array is a handful of per-bit flops, not a RAM, so it is
  // reset explicitly; that is what discards a partial count on reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (reset) begin
        r_cnt[i] <= '0;
      end else begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edge_capture & r_irq_mask);

endmodule

// File: tb/tb_core_sht_data_in.sv
// ---------------------------------------------------------------------------
// tb_core_sht_data_in
//
// Directed bench for core_sht_data_in with WIDTH=8, FILTER_CYCLES=4,
// EDGE_TYPE=0 (rising). Inputs change 1 ns after a rising clock edge and
// outputs are inspected at the same point, well clear of the active edge.
// ---------------------------------------------------------------------------
module tb_core_sht_data_in;

  localparam int WIDTH = 8;
  localparam int FC    = 4;

  logic             clk;
  logic             reset;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] in_port;
  logic             irq;

  int n_assert = 0;
  int n_fail   = 0;

  core_sht_data_in #(
    .WIDTH(WIDTH),
    .FILTER_CYCLES(FC),
    .EDGE_TYPE(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .in_port(in_port),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    step();
    d          = readdata;
    chipselect = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;

    // Reset values
    step(); step(); step();
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    bus_read(2'd0, rd); chk("rst_data", rd, 32'h0);
    bus_read(2'd2, rd); chk("rst_mask", rd, 32'h0);
    bus_read(2'd3, rd); chk("rst_cap", rd, 32'h0);

    // Filtered rising edge on bit 0: irq rises at edge k+5 and not before
    bus_write(2'd2, 32'h01);
    in_port = 8'h01;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rise_irq_low_k%0d", i), {31'b0, irq}, 32'h0);
    end
    step();
    chk("rise_irq_high_k5", {31'b0, irq}, 32'h1);
    bus_read(2'd0, rd); chk("rise_data", rd, 32'h01);
    bus_read(2'd3, rd); chk("rise_cap", rd, 32'h01);

    // readdata holds without a read; DATA and reserved ignore writes
    step(); step();
    chk("rd_hold", readdata, 32'h01);
    bus_write(2'd0, 32'hFF);
    bus_read(2'd0, rd); chk("data_wr_ignored", rd, 32'h01);
    bus_write(2'd1, 32'hFF);
    bus_read(2'd1, rd); chk("reserved_reads_0", rd, 32'h0);

    // Glitch rejection: 3-cycle pulse on bit 2
    in_port = 8'h05;
    step(); step(); step();
    in_port = 8'h01;
    for (int i = 0; i < 10; i++) step();
    bus_read(2'd0, rd); chk("glitch_data", rd, 32'h01);
    bus_read(2'd3, rd); chk("glitch_cap", rd, 32'h01);

    // W1C and mask
    in_port = 8'h05;
    for (int i = 0; i < 8; i++) step();
    bus_read(2'd3, rd); chk("cap_05", rd, 32'h05);
    bus_write(2'd3, 32'h04);
    bus_read(2'd3, rd); chk("w1c_cap_01", rd, 32'h01);
    bus_write(2'd2, 32'h00);
    chk("mask_off_irq", {31'b0, irq}, 32'h0);
    bus_write(2'd2, 32'h01);
    chk("mask_on_irq", {31'b0, irq}, 32'h1);

    // Capture wins over clear
    in_port = 8'h04;
    for (int i = 0; i < 10; i++) step();
    bus_write(2'd3, 32'h01);
    chk("pre_race_irq_low", {31'b0, irq}, 32'h0);
    in_port = 8'h05;
    for (int i = 0; i < 5; i++) step();
    chk("race_irq_before", {31'b0, irq}, 32'h0);
    bus_write(2'd3, 32'h01);  // lands on the edge where bit 0 rises
    chk("race_irq_high", {31'b0, irq}, 32'h1);
    bus_read(2'd3, rd); chk("race_cap", rd, 32'h01);
    bus_write(2'd3, 32'h01);
    bus_read(2'd3, rd); chk("w1c_after_race", rd, 32'h0);
    chk("w1c_after_race_irq", {31'b0, irq}, 32'h0);

    // Reset mid-filter: partial count discarded, capture at R+FC+2
    in_port = 8'h00;
    for (int i = 0; i < 10; i++) step();
    bus_write(2'd3, 32'hFF);
    in_port = 8'h01;
    step(); step();          // change reaches s2
    step(); step();          // two counting cycles
    reset = 1'b1;
    step(); step();          // last reset edge is R
    reset = 1'b0;
    bus_write(2'd2, 32'h01); // edge R+1
    chk("mid_rst_irq_r1", {31'b0, irq}, 32'h0);
    for (int i = 2; i < FC + 2; i++) begin
      step();
      chk($sformatf("mid_rst_irq_r%0d", i), {31'b0, irq}, 32'h0);
    end
    step();                  // edge R+FC+2
    chk("mid_rst_irq_high", {31'b0, irq}, 32'h1);
    bus_read(2'd3, rd); chk("mid_rst_cap", rd, 32'h01);
    bus_read(2'd0, rd); chk("mid_rst_data", rd, 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
